ppu_fetch_tracker: RTL and testbench

- Parametrised, single-clock successor to the per-mapper PPU fetch snooping logic.
- Synchronises the PPU read strobe and classifies each fetch as NT, AT or PT, including the dummy-fetch pattern.
- Captures nametable coordinate LSBs for attribute remapping.
- Generates a mapper IRQ in one of two runtime modes: legacy A12 latch, or filtered-A12 scanline counter.
- Instantiated by mappers that remap attribute fetches or need scanline IRQs.

---
 rtl/mapper_pkg.sv | 26 ++
 rtl/ppu_oe_sync.sv | 31 +++
 rtl/ppu_fetch_tracker.sv | 201 ++++++++++++++++++++
 tb/tb_ppu_fetch_tracker.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mapper_pkg.sv
// Shared constants for mapper PPU snooping blocks: register select codes,
// IRQ mode codes, save-state addresses and the attribute-fetch predictor.
package mapper_pkg;

    typedef enum logic [1:0] {
        REG_LATCH   = 2'd0,
        REG_RELOAD  = 2'd1,
        REG_DIS_ACK = 2'd2,
        REG_EN      = 2'd3
    } reg_sel_e;

    localparam logic IRQM_LEGACY  = 1'b0;
    localparam logic IRQM_COUNTER = 1'b1;

    localparam logic [7:0] SS_ADDR_CNT    = 8'd0;
    localparam logic [7:0] SS_ADDR_LATCH  = 8'd1;
    localparam logic [7:0] SS_ADDR_FLAGS  = 8'd2;
    localparam logic [7:0] SS_ADDR_LOWCNT = 8'd3;

    // An attribute fetch follows an NT fetch whose two older neighbours agree on A13;
    // this also catches the dummy NT fetches at the end of a scanline.
    function automatic logic predict_at(input logic a13, input logic a13_dd, input logic a13_ddd);
        return a13 & ((~a13_dd & ~a13_ddd) | (a13_dd & a13_ddd));
    endfunction

endpackage

// File: rtl/ppu_oe_sync.sv
// Multi-stage synchroniser for the asynchronous PPU read strobe with a
// registered one-cycle pulse on each synchronised falling edge.
module ppu_oe_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;
    logic                   fall_q;

    // Cleared to 0 so a strobe already low at reset release never produces a pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
            last_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            last_q <= sync_q[SYNC_STAGES-1];
            fall_q <= last_q & ~sync_q[SYNC_STAGES-1];
        end
    end

    assign fall_o = fall_q;

endmodule

// File: rtl/ppu_fetch_tracker.sv
// PPU fetch classifier (NT/AT/PT), NT coordinate capture and mapper IRQ
// (legacy A12 latch or filtered-A12 scanline counter). Save-state port: PPU_FETCH_TRACKER_SS_EN.
module ppu_fetch_tracker
    import mapper_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int A12_FILTER  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             map_rst,
    input  logic             ppu_oe,
    input  logic [13:0]      ppu_addr,
    input  logic             reg_we,
    input  logic [1:0]       reg_sel,
    input  logic [CNT_W-1:0] reg_dat,
    input  logic             irq_mode,
`ifdef PPU_FETCH_TRACKER_SS_EN
    input  logic             ss_act,
    input  logic             ss_we,
    input  logic [7:0]       ss_addr,
    input  logic [7:0]       ss_wdat,
    output logic [7:0]       ss_rdat,
`endif
    output logic             irq,
    output logic             at_fetch,
    output logic             at_nt_x,
    output logic             at_nt_y,
    output logic             fetch_stb,
    output logic             a12_rise
);

    localparam int               LOW_W   = $clog2(A12_FILTER + 1);
    localparam logic [LOW_W-1:0] LOW_MAX = LOW_W'(A12_FILTER);

    logic             stb;
    logic             wr_en, wr_reload, wr_dis;
    logic             unused_addr;

    logic [2:0]       hist_q, hist_d;
    logic             at_q, at_d;
    logic [1:0]       nt_q, nt_d;
    logic [1:0]       at_nt_q, at_nt_d;
    logic [LOW_W-1:0] low_cnt_q, low_cnt_d;
    logic             a12_s_q, a12_s_d;
    logic             rise_q, rise_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] latch_q, latch_d;
    logic             reload_q, reload_d;
    logic             pend_q, pend_d;
    logic             en_q, en_d;
    logic             leg_q, leg_d;
    logic             mode_q;

    ppu_oe_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_oe_sync (
        .clk_i (clk),
        .rst_i (map_rst),
        .d_i   (ppu_oe),
        .fall_o(stb)
    );

`ifdef PPU_FETCH_TRACKER_SS_EN
    assign wr_en = reg_we & ~ss_act;
`else
    assign wr_en = reg_we;
`endif
    assign wr_reload   = wr_en && (reg_sel == REG_RELOAD);
    assign wr_dis      = wr_en && (reg_sel == REG_DIS_ACK);
    assign unused_addr = &{1'b0, ppu_addr[11:6], ppu_addr[4:1]};

    always_comb begin
        hist_d    = hist_q;
        at_d      = at_q;
        nt_d      = nt_q;
        at_nt_d   = at_nt_q;
        low_cnt_d = low_cnt_q;
        a12_s_d   = a12_s_q;
        cnt_d     = cnt_q;
        latch_d   = latch_q;
        reload_d  = reload_q;
        pend_d    = pend_q;
        en_d      = en_q;
        leg_d     = leg_q;
        rise_d    = stb && ppu_addr[12] && !a12_s_q && (low_cnt_q == LOW_MAX);

        if (stb) begin
            hist_d  = {hist_q[1:0], ppu_addr[13]};
            at_d    = predict_at(ppu_addr[13], hist_q[1], hist_q[2]);
            nt_d    = {ppu_addr[5], ppu_addr[0]};
            at_nt_d = nt_q;
            a12_s_d = ppu_addr[12];
            if (ppu_addr[12]) begin
                low_cnt_d = '0;
            end else if (low_cnt_q != LOW_MAX) begin
                low_cnt_d = low_cnt_q + 1'b1;
            end
            if (irq_mode == IRQM_LEGACY && ppu_addr[12]) begin
                leg_d = 1'b1;
            end
        end

        if (wr_en) begin
            case (reg_sel)
                REG_LATCH:   latch_d = reg_dat;
                REG_RELOAD: begin
                    reload_d = 1'b1;
                    cnt_d    = '0;
                end
                REG_DIS_ACK: en_d = 1'b0;
                default:     en_d = 1'b1;
            endcase
        end

        // A same-cycle reload write is folded into the rise so reload_pend ends cleared.
        if (rise_q && irq_mode == IRQM_COUNTER) begin
            if (cnt_q == '0 || reload_q || wr_reload) begin
                cnt_d    = latch_q;
                reload_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
            if (cnt_d == '0 && en_q) begin
                pend_d = 1'b1;
            end
        end

        if (wr_dis || irq_mode != mode_q) begin
            pend_d = 1'b0;
            leg_d  = 1'b0;
        end

`ifdef PPU_FETCH_TRACKER_SS_EN
        if (ss_act && ss_we) begin
            case (ss_addr)
                SS_ADDR_CNT:    cnt_d = CNT_W'(ss_wdat);
                SS_ADDR_LATCH:  latch_d = CNT_W'(ss_wdat);
                SS_ADDR_FLAGS:  {reload_d, pend_d, en_d, leg_d} = ss_wdat[3:0];
                SS_ADDR_LOWCNT: low_cnt_d = LOW_W'(ss_wdat);
                default: ;
            endcase
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (map_rst) begin
            hist_q    <= '0;
            at_q      <= 1'b0;
            nt_q      <= '0;
            at_nt_q   <= '0;
            low_cnt_q <= '0;
            a12_s_q   <= 1'b0;
            rise_q    <= 1'b0;
            cnt_q     <= '0;
            latch_q   <= '0;
            reload_q  <= 1'b0;
            pend_q    <= 1'b0;
            en_q      <= 1'b0;
            leg_q     <= 1'b0;
            mode_q    <= IRQM_LEGACY;
        end else begin
            hist_q    <= hist_d;
            at_q      <= at_d;
            nt_q      <= nt_d;
            at_nt_q   <= at_nt_d;
            low_cnt_q <= low_cnt_d;
            a12_s_q   <= a12_s_d;
            rise_q    <= rise_d;
            cnt_q     <= cnt_d;
            latch_q   <= latch_d;
            reload_q  <= reload_d;
            pend_q    <= pend_d;
            en_q      <= en_d;
            leg_q     <= leg_d;
            mode_q    <= irq_mode;
        end
    end

`ifdef PPU_FETCH_TRACKER_SS_EN
    always_comb begin
        ss_rdat = 8'hFF;
        case (ss_addr)
            SS_ADDR_CNT:    ss_rdat = 8'(cnt_q);
            SS_ADDR_LATCH:  ss_rdat = 8'(latch_q);
            SS_ADDR_FLAGS:  ss_rdat = {4'b0000, reload_q, pend_q, en_q, leg_q};
            SS_ADDR_LOWCNT: ss_rdat = 8'(low_cnt_q);
            default:        ss_rdat = 8'hFF;
        endcase
    end
`endif

    assign irq       = (irq_mode == IRQM_COUNTER) ? pend_q : ((leg_q | a12_s_q) & en_q);
    assign at_fetch  = at_q;
    assign at_nt_x   = at_nt_q[0];
    assign at_nt_y   = at_nt_q[1];
    assign fetch_stb = stb;
    assign a12_rise  = rise_q;

endmodule

// File: tb/tb_ppu_fetch_tracker.sv
// Self-checking bench for ppu_fetch_tracker: fetch-pattern table, hand-written
// IRQ corner sequences and a randomized phase against a transaction-level model.
module tb_ppu_fetch_tracker;

    localparam int F = 4;

    logic        clk = 1'b0;
    logic        map_rst = 1'b1;
    logic        ppu_oe = 1'b1;
    logic [13:0] ppu_addr = '0;
    logic        reg_we = 1'b0;
    logic [1:0]  reg_sel = '0;
    logic [7:0]  reg_dat = '0;
    logic        irq_mode = 1'b0;
    logic        irq, at_fetch, at_nt_x, at_nt_y, fetch_stb, a12_rise;
`ifdef PPU_FETCH_TRACKER_SS_EN
    logic        ss_act = 1'b0;
    logic        ss_we = 1'b0;
    logic [7:0]  ss_addr = '0;
    logic [7:0]  ss_wdat = '0;
    logic [7:0]  ss_rdat;
`endif

    ppu_fetch_tracker #(.CNT_W(8), .A12_FILTER(F), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .map_rst  (map_rst),
        .ppu_oe   (ppu_oe),
        .ppu_addr (ppu_addr),
        .reg_we   (reg_we),
        .reg_sel  (reg_sel),
        .reg_dat  (reg_dat),
        .irq_mode (irq_mode),
`ifdef PPU_FETCH_TRACKER_SS_EN
        .ss_act   (ss_act),
        .ss_we    (ss_we),
        .ss_addr  (ss_addr),
        .ss_wdat  (ss_wdat),
        .ss_rdat  (ss_rdat),
`endif
        .irq      (irq),
        .at_fetch (at_fetch),
        .at_nt_x  (at_nt_x),
        .at_nt_y  (at_nt_y),
        .fetch_stb(fetch_stb),
        .a12_rise (a12_rise)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Transaction-level reference model
    bit a13_hist[$];
    bit ntx_hist[$];
    bit nty_hist[$];
    int lowrun;
    bit m_a12s, m_at, m_ntx, m_nty, m_rise;
    int m_cnt, m_latch;
    bit m_reload, m_pend, m_en, m_leg, m_mode;

    typedef struct {
        logic [13:0] addr;
        logic        at;
        logic        x;
        logic        y;
    } vec_t;
    vec_t tbl[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic bit m_irq();
        return m_mode ? m_pend : ((m_leg | m_a12s) & m_en);
    endfunction

    task automatic m_reset();
        a13_hist = '{0, 0, 0};
        ntx_hist = '{0};
        nty_hist = '{0};
        lowrun = 0;
        m_a12s = 0; m_at = 0; m_ntx = 0; m_nty = 0; m_rise = 0;
        m_cnt = 0; m_latch = 0;
        m_reload = 0; m_pend = 0; m_en = 0; m_leg = 0;
    endtask

    task automatic m_write(input logic [1:0] sel, input logic [7:0] dat);
        case (sel)
            2'd0: m_latch = dat;
            2'd1: begin m_reload = 1; m_cnt = 0; end
            2'd2: begin m_en = 0; m_pend = 0; m_leg = 0; end
            default: m_en = 1;
        endcase
    endtask

    task automatic m_fetch(input logic [13:0] a, input bit wr, input logic [1:0] sel, input logic [7:0] dat);
        bit a13 = a[13];
        bit a12 = a[12];
        m_at = a13 && (a13_hist[$-1] == a13_hist[$-2]);
        a13_hist.push_back(a13);
        void'(a13_hist.pop_front());
        m_ntx = ntx_hist[$];
        m_nty = nty_hist[$];
        ntx_hist.push_back(a[0]);
        nty_hist.push_back(a[5]);
        void'(ntx_hist.pop_front());
        void'(nty_hist.pop_front());
        m_rise = a12 && !m_a12s && (lowrun >= F);
        lowrun = a12 ? 0 : lowrun + 1;
        m_a12s = a12;
        if (!m_mode && a12) m_leg = 1;
        if (wr) m_write(sel, dat);
    endtask

    task automatic m_rise_step(input bit wr, input logic [1:0] sel, input logic [7:0] dat);
        int  latch_old = m_latch;
        bit  en_old = m_en;
        if (wr) m_write(sel, dat);
        if (m_cnt == 0 || m_reload) begin
            m_cnt = latch_old;
            m_reload = 0;
        end else begin
            m_cnt = m_cnt - 1;
        end
        if (m_cnt == 0 && en_old && !(wr && sel == 2'd2)) m_pend = 1;
    endtask

    // One PPU fetch; wph=3 writes in the fetch_stb cycle, wph=4 in the a12_rise cycle
    task automatic fetch(input logic [13:0] a, input int wph, input logic [1:0] sel, input logic [7:0] dat);
        @(negedge clk);
        ppu_addr = a;
        ppu_oe = 1'b0;
        @(negedge clk);
        chk("stb_early1", fetch_stb, 0);
        @(negedge clk);
        chk("stb_early2", fetch_stb, 0);
        @(negedge clk);
        chk("stb_latency", fetch_stb, 1);
        if (wph == 3) begin reg_we = 1'b1; reg_sel = sel; reg_dat = dat; end
        @(negedge clk);
        reg_we = 1'b0;
        m_fetch(a, wph == 3, sel, dat);
        chk("at_fetch", at_fetch, m_at);
        chk("at_nt_x", at_nt_x, m_ntx);
        chk("at_nt_y", at_nt_y, m_nty);
        chk("a12_rise", a12_rise, m_rise);
        ppu_oe = 1'b1;
        if (wph == 4) begin reg_we = 1'b1; reg_sel = sel; reg_dat = dat; end
        @(negedge clk);
        reg_we = 1'b0;
        if (m_rise && m_mode) m_rise_step(wph == 4, sel, dat);
        else if (wph == 4) m_write(sel, dat);
        chk("irq_fetch", irq, m_irq());
        chk("stb_pulse", fetch_stb, 0);
        @(negedge clk);
    endtask

    task automatic reg_write(input logic [1:0] sel, input logic [7:0] dat);
        @(negedge clk);
        reg_we = 1'b1; reg_sel = sel; reg_dat = dat;
        @(negedge clk);
        reg_we = 1'b0;
        m_write(sel, dat);
        chk("irq_write", irq, m_irq());
    endtask

    task automatic set_mode(input bit m);
        @(negedge clk);
        irq_mode = m;
        m_mode = m; m_pend = 0; m_leg = 0;
        @(negedge clk);
        chk("irq_mode_chg", irq, m_irq());
    endtask

    // F low fetches, then a high fetch: one filtered A12 rise
    task automatic do_rise(input int wph, input logic [1:0] sel, input logic [7:0] dat);
        for (int i = 0; i < F; i++) fetch(14'($urandom) & 14'h2FFF, 0, 2'd0, 8'd0);
        fetch(14'h1000 | (14'($urandom) & 14'h0FFF), wph, sel, dat);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, checks %0d/%0d", pass_cnt, total_cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{14'h2000, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{14'h23C0, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{14'h0000, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{14'h0008, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{14'h2021, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{14'h23C0, 1'b1, 1'b1, 1'b1};
        tbl[6]  = '{14'h0010, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{14'h2000, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{14'h2400, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{14'h2800, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{14'h23C0, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{14'h2021, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{14'h0001, 1'b0, 1'b1, 1'b1};
        tbl[13] = '{14'h2020, 1'b1, 1'b1, 1'b0};
        tbl[14] = '{14'h0000, 1'b0, 1'b0, 1'b1};

        m_mode = 0;
        m_reset();
        repeat (3) @(negedge clk);
        map_rst = 1'b0;
        chk("rst_irq", irq, 0);
        chk("rst_at", at_fetch, 0);
        chk("rst_ntx", at_nt_x, 0);
        chk("rst_nty", at_nt_y, 0);
        chk("rst_stb", fetch_stb, 0);
        chk("rst_rise", a12_rise, 0);
        repeat (3) @(negedge clk);

        // Fetch classification table, including the dummy-NT pattern
        for (int i = 0; i < 15; i++) begin
            fetch(tbl[i].addr, 0, 2'd0, 8'd0);
            chk("tbl_at", at_fetch, tbl[i].at);
            chk("tbl_x", at_nt_x, tbl[i].x);
            chk("tbl_y", at_nt_y, tbl[i].y);
        end

        // Counter mode: latch=3 -> IRQ on the 4th and 8th rise, ack in between
        set_mode(1);
        reg_write(2'd0, 8'd3);
        reg_write(2'd3, 8'd0);
        for (int k = 1; k <= 8; k++) begin
            do_rise(0, 2'd0, 8'd0);
            chk("cnt_irq", irq, (k == 4 || k == 8));
            if (k == 4) begin
                reg_write(2'd2, 8'd0);
                chk("cnt_ack", irq, 0);
                reg_write(2'd3, 8'd0);
            end
        end

        // Glitch: only two low fetches before A12 rises again
        reg_write(2'd2, 8'd0);
        reg_write(2'd0, 8'd0);
        reg_write(2'd3, 8'd0);
        fetch(14'h1000, 0, 2'd0, 8'd0);
        fetch(14'h0000, 0, 2'd0, 8'd0);
        fetch(14'h0000, 0, 2'd0, 8'd0);
        fetch(14'h1000, 0, 2'd0, 8'd0);
        chk("glitch_irq", irq, 0);
        do_rise(0, 2'd0, 8'd0);
        chk("latch0_irq", irq, 1);

        // Legacy latch mode
        set_mode(0);
        fetch(14'h0000, 0, 2'd0, 8'd0);
        chk("leg_idle", irq, 0);
        fetch(14'h1000, 0, 2'd0, 8'd0);
        chk("leg_set", irq, 1);
        fetch(14'h0000, 0, 2'd0, 8'd0);
        chk("leg_hold", irq, 1);
        reg_write(2'd2, 8'd0);
        chk("leg_ack", irq, 0);
        reg_write(2'd3, 8'd0);
        chk("leg_reen", irq, 0);
        fetch(14'h1000, 3, 2'd2, 8'd0);
        chk("leg_ack_wins", irq, 0);
        reg_write(2'd3, 8'd0);
        fetch(14'h0000, 0, 2'd0, 8'd0);
        chk("leg_not_set", irq, 0);

        // Reload write coincident with a rise
        set_mode(1);
        reg_write(2'd0, 8'd2);
        reg_write(2'd2, 8'd0);
        reg_write(2'd3, 8'd0);
        do_rise(4, 2'd1, 8'd0);
        chk("rld_rise0", irq, 0);
        do_rise(0, 2'd0, 8'd0);
        chk("rld_rise1", irq, 0);
        do_rise(0, 2'd0, 8'd0);
        chk("rld_rise2", irq, 1);

        // Reset mid-count (cnt=2) with ppu_oe already low
        reg_write(2'd0, 8'd3);
        reg_write(2'd2, 8'd0);
        reg_write(2'd3, 8'd0);
        reg_write(2'd1, 8'd0);
        do_rise(0, 2'd0, 8'd0);
        do_rise(0, 2'd0, 8'd0);
        @(negedge clk);
        ppu_oe = 1'b0;
        @(negedge clk);
        map_rst = 1'b1;
        @(negedge clk);
        map_rst = 1'b0;
        m_reset();
        chk("mrst_irq", irq, 0);
        chk("mrst_at", at_fetch, 0);
        chk("mrst_ntx", at_nt_x, 0);
        chk("mrst_nty", at_nt_y, 0);
        chk("mrst_stb", fetch_stb, 0);
        chk("mrst_rise", a12_rise, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("mrst_no_stb", fetch_stb, 0);
        end
        ppu_oe = 1'b1;
        repeat (3) @(negedge clk);
        reg_write(2'd0, 8'd3);
        reg_write(2'd3, 8'd0);
        for (int k = 1; k <= 4; k++) begin
            do_rise(0, 2'd0, 8'd0);
            chk("mrst_cnt_irq", irq, (k == 4));
        end

        // Randomized phase
        for (int i = 0; i < 200; i++) begin
            int r = $urandom_range(0, 15);
            if (r < 3) begin
                reg_write(2'($urandom_range(0, 3)), 8'($urandom_range(0, 3)));
            end else if (r == 3) begin
                set_mode(!m_mode);
            end else begin
                logic [13:0] a = 14'($urandom);
                a[12] = ($urandom_range(0, 3) == 0);
                fetch(a, 0, 2'd0, 8'd0);
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
